// File: rtl/lsu_handshake.sv
// Load/store unit bridging the core's single-cycle memory stage to a variable-latency
// data memory port: request/ack handshake, byte lanes, load extension, fault detection.

module lsu_handshake #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        lsu_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic             fault_q;

    logic             access;
    logic             is_store;
    logic [1:0]       size;
    logic             illegal_f3;
    logic             misaligned;
    logic             bad_access;
    logic             timeout_hit;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      load_ext_d;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;

    // Request decode; a simultaneous read and write is treated as a store.
    assign access   = MemRead | MemWrite;
    assign is_store = MemWrite;
    assign size     = funct3[1:0];

    always_comb begin
        illegal_f3 = 1'b1;
        if (is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
                default:                illegal_f3 = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
                default:                                 illegal_f3 = 1'b1;
            endcase
        end
    end

    assign misaligned = ((size == SZ_HALF) && address[0])
                     || ((size == SZ_WORD) && (address[1:0] != 2'b00));
    assign bad_access = illegal_f3 | misaligned;

    // Byte lanes and replicated store data for the access size.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = write_data;
        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << address[1:0];
                wdata_d = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                be_d    = address[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{write_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = write_data;
            end
        endcase
    end

    // Lane select uses the offset captured at issue, not the live address.
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        load_ext_d = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext_d = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext_d = {24'd0, sel_byte};
            3'b001:  load_ext_d = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext_d = {16'd0, sel_half};
            default: load_ext_d = mem_rdata;
        endcase
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Core-facing status is combinational so the core sees it in the issue cycle.
    assign stall     = ((state_q == S_IDLE) && access && !bad_access) || (state_q == S_WAIT);
    assign lsu_fault = ((state_q == S_IDLE) && access && bad_access) || fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            fault_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            read_data <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        if (bad_access) begin
                            read_data <= 32'd0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {address[31:2], 2'b00};
                            mem_wdata <= wdata_d;
                            mem_be    <= be_d;
                            funct3_q  <= funct3;
                            off_q     <= address[1:0];
                            cnt_q     <= '0;
                            state_q   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // An ack arriving on the final allowed cycle beats the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            read_data <= load_ext_d;
                        end
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        read_data <= 32'd0;
                        fault_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    fault_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake: load/store sizes, faults, timeout and reset recovery.

module tb_lsu_handshake;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        lsu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    lsu_handshake #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .lsu_fault  (lsu_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        funct3     = 3'd0;
        address    = 32'd0;
        write_data = 32'd0;
    endtask

    // Full access: issue, lat cycles without ack, ack cycle, DONE cycle.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdat, input int lat,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic [31:0] exp_rd);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; write_data = wd;
        mem_ack = 1'b0;
        #1;
        chk({name, "_issue_stall"}, 32'(stall), 32'd1);
        chk({name, "_issue_req"}, 32'(mem_req), 32'd0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); #1;
            chk({name, "_wait_req"}, 32'(mem_req), 32'd1);
            chk({name, "_wait_stall"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rdat;
        #1;
        chk({name, "_req"}, 32'(mem_req), 32'd1);
        chk({name, "_stall"}, 32'(stall), 32'd1);
        chk({name, "_be"}, 32'(mem_be), 32'(ebe));
        chk({name, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({name, "_we"}, 32'(mem_we), 32'(wr));
        if (wr) chk({name, "_wdata"}, mem_wdata, ewd);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #1;
        chk({name, "_done_stall"}, 32'(stall), 32'd0);
        chk({name, "_done_req"}, 32'(mem_req), 32'd0);
        chk({name, "_done_fault"}, 32'(lsu_fault), 32'd0);
        chk({name, "_rdata"}, read_data, exp_rd);
    endtask

    // Faulting access in IDLE: combinational fault, no stall, no request.
    task automatic run_fault(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; write_data = 32'hFFFF_FFFF;
        #1;
        chk({name, "_fault"}, 32'(lsu_fault), 32'd1);
        chk({name, "_stall"}, 32'(stall), 32'd0);
        chk({name, "_req"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk({name, "_rdata_clr"}, read_data, 32'd0);
        chk({name, "_req_after"}, 32'(mem_req), 32'd0);
        chk({name, "_fault_after"}, 32'(lsu_fault), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        clear_inputs();
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        @(negedge clk); #1;
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(lsu_fault), 32'd0);
        rst = 1'b0;

        // Loads, back-to-back: each issues in the IDLE cycle right after DONE.
        run_access("lw",  1, 0, 3'b010, 32'h3C, 32'd0, 32'h0000_0041, 0, 4'b1111, 32'd0, 32'h0000_0041);
        run_access("lb",  1, 0, 3'b000, 32'h43, 32'd0, 32'h80FF_7F01, 0, 4'b1000, 32'd0, 32'hFFFF_FF80);
        run_access("lbu", 1, 0, 3'b100, 32'h43, 32'd0, 32'h80FF_7F01, 1, 4'b1000, 32'd0, 32'h0000_0080);
        run_access("lh",  1, 0, 3'b001, 32'h42, 32'd0, 32'h80FF_7F01, 2, 4'b1100, 32'd0, 32'hFFFF_80FF);
        run_access("lhu", 1, 0, 3'b101, 32'h40, 32'd0, 32'h80FF_7F01, 0, 4'b0011, 32'd0, 32'h0000_7F01);

        // Stores leave read_data untouched.
        run_access("sb", 0, 1, 3'b000, 32'h42, 32'h1234_56AB, 32'hDEAD_BEEF, 1, 4'b0100, 32'hABAB_ABAB, 32'h0000_7F01);
        run_access("sh", 0, 1, 3'b001, 32'h46, 32'h1234_BEEF, 32'hDEAD_BEEF, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_7F01);
        run_access("sw", 1, 1, 3'b010, 32'h48, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_7F01);

        run_fault("mis_lw", 1, 0, 3'b010, 32'h3E);
        run_access("lw2", 1, 0, 3'b010, 32'h3C, 32'd0, 32'h0000_0041, 0, 4'b1111, 32'd0, 32'h0000_0041);
        run_fault("mis_lh", 1, 0, 3'b001, 32'h41);
        run_fault("ill_ld", 1, 0, 3'b011, 32'h40);
        run_fault("ill_st", 1, 1, 3'b100, 32'h40);
        run_access("lw3", 1, 0, 3'b010, 32'h3C, 32'd0, 32'h0000_0041, 0, 4'b1111, 32'd0, 32'h0000_0041);

        // Stray ack while idle must not disturb read_data.
        @(negedge clk);
        clear_inputs();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #1;
        chk("idle_ack_rdata", read_data, 32'h0000_0041);
        chk("idle_ack_req", 32'(mem_req), 32'd0);

        // Timeout: no ack, request held 15 cycles, then one-cycle fault in DONE.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b010; address = 32'h10;
        #1;
        chk("to_issue_stall", 32'(stall), 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (mem_req) n++;
            else break;
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_done_fault", 32'(lsu_fault), 32'd1);
        chk("to_done_stall", 32'(stall), 32'd0);
        chk("to_done_rdata", read_data, 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("to_fault_pulse", 32'(lsu_fault), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Ack on the last allowed cycle wins over the timeout.
        run_access("ack_edge", 1, 0, 3'b010, 32'h20, 32'd0, 32'h0000_0077, 14, 4'b1111, 32'd0, 32'h0000_0077);
        run_access("lw_lat3", 1, 0, 3'b010, 32'h24, 32'd0, 32'h5A5A_5A5A, 3, 4'b1111, 32'd0, 32'h5A5A_5A5A);

        // Reset three cycles into WAIT drops everything before the next edge.
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; address = 32'h30;
        repeat (3) @(negedge clk);
        #1;
        chk("rw_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("rw_req", 32'(mem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_fault", 32'(lsu_fault), 32'd0);
        chk("rw_rdata", read_data, 32'd0);
        chk("rw_be", 32'(mem_be), 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        chk("rw_we", 32'(mem_we), 32'd0);
        chk("rw_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_0000;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #1;
        chk("late_ack_rdata", read_data, 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);

        run_access("post_rst", 1, 0, 3'b000, 32'h51, 32'd0, 32'h0000_7F00, 0, 4'b0010, 32'd0, 32'h0000_007F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_handshake.md
# lsu_handshake

Load/store unit between the core's ALU/register-file outputs and a variable-latency data memory port. It replaces the zero-latency data memory path.

- Accepts one load or store per instruction and stalls the core until the memory acknowledges.
- Generates byte enables and replicated write data for sb/sh/sw.
- Sign- or zero-extends lb/lh/lbu/lhu results.
- Flags misaligned or illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 15: maximum WAIT cycles without `mem_ack` before the access is aborted. Legal range is 1–255.

One clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  load request from control
- MemWrite  in  1  store request from control
- funct3  in  3  instruction[14:12]; selects size and signedness
- address  in  32  byte address from the ALU
- write_data  in  32  rs2 value
- read_data  out  32  extended load result (registered)
- stall  out  1  core holds PC and register write while high
- lsu_fault  out  1  misaligned or illegal-funct3 access, or bus timeout
- mem_req  out  1  memory request (registered)
- mem_we  out  1  1 = write
- mem_addr  out  32  `{address[31:2], 2'b00}`, latched
- mem_wdata  out  32  replicated store data, latched
- mem_be  out  4  byte enables, latched
- mem_rdata  in  32  memory read word, valid with `mem_ack`
- mem_ack  in  1  one-cycle completion strobe

## Operation
The unit has three states: IDLE, WAIT and DONE.

- **Access:** `access = MemRead | MemWrite`. If both are high, the access is a store.
- **Illegal funct3:**
  - Load legal values: 000, 001, 010, 100, 101.
  - Store legal values: 000, 001, 010.
- **Misaligned:**
  - Half-word accesses with `address[0]=1`.
  - Word accesses with `address[1:0]!=0`.
- **IDLE, legal access:**
  - Latch `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, funct3 and `address[1:0]`.
  - Set `mem_req=1` and go to WAIT.
  - `stall=1` combinationally in this cycle.
- **IDLE, illegal or misaligned access:**
  - No request is issued; `stall=0`; `lsu_fault=1` combinationally for that cycle.
  - `read_data` is cleared to 0 on the next edge, and the instruction retires as a no-op.
- **WAIT:**
  - `stall=1` and `mem_req` is held high.
  - On `mem_ack`:
    - Drop `mem_req`.
    - For loads, register the extended `mem_rdata` into `read_data`.
    - Go to DONE.
  - The wait counter increments each WAIT cycle without an ack. When it reaches TIMEOUT:
    - Drop `mem_req`.
    - Set `read_data=0`.
    - Assert `lsu_fault` as a registered one-cycle pulse in DONE.
    - Go to DONE.
- **DONE:**
  - `stall=0`; the core retires the instruction on this edge.
  - Any access inputs are ignored, which prevents re-issuing the same instruction.
  - Go to IDLE unconditionally.
- **Byte enables:**
  - sb: `4'b0001 << address[1:0]`
  - sh: `4'b0011` if `address[1]=0`, else `4'b1100`
  - sw: `4'b1111`
- **Store data:**
  - sb: `{4{write_data[7:0]}}`
  - sh: `{2{write_data[15:0]}}`
  - sw: `write_data`
- **Load extend:** select the byte or half-word from `mem_rdata` using the latched `address[1:0]`.
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes the word through.
- **Store result:** a store leaves `read_data` unchanged.
- **`mem_ack` outside WAIT:** ignored.
- **`mem_ack` on the timeout cycle:** the ack wins; no fault is raised.

## Timing
- **Reset values:** asynchronous `rst` forces:
  - state to IDLE, wait counter to 0;
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`;
  - `read_data=0`, registered `lsu_fault=0`.
- **Reset mid-operation:** `rst` during WAIT drops `mem_req` immediately, without waiting for a clock edge. An outstanding ack after reset is ignored.
- **Minimum latency:** 3 cycles per memory instruction.
  - Cycle 0: IDLE, `stall=1`.
  - Cycle 1: WAIT, `mem_req=1`, `mem_ack=1`.
  - Cycle 2: DONE, `stall=0`, `read_data` valid.
- **Ack latency:** each extra cycle of `mem_ack` latency adds one stall cycle.
- **Timeout:** the worst case is TIMEOUT+2 cycles.
- **Request stability:** `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable for the whole time `mem_req=1`.
- **Non-memory instructions:** zero-cycle pass-through; `stall=0` while in IDLE with `access=0`.
- **Back-to-back accesses:** a second memory instruction is accepted in the IDLE cycle following DONE.

## Test plan
- **lw, zero latency ack:** `address=0x3C`, `mem_rdata=0x00000041`, ack in the first WAIT cycle.
  - Cycle 1: `mem_req=1`, `mem_be=1111`, `mem_addr=0x3C`.
  - Cycle 2: `read_data=0x41`, `stall` pattern 1,1,0.
- **lb / lbu, same word:** `address=0x43`, `mem_rdata=0x80FF7F01`.
  - lb gives `read_data=0xFFFFFF80`.
  - lbu gives `0x00000080`.
- **sb, byte lane 2:** `address=0x42`, `write_data=0x123456AB`.
  - Requires `mem_we=1`, `mem_be=0100`, `mem_wdata=0xABABABAB`, `mem_addr=0x40`.
  - `read_data` is unchanged.
- **Misaligned lw:** `address=0x3E`.
  - `lsu_fault=1`, `stall=0` in the same cycle.
  - `mem_req` never rises; `read_data=0` next cycle.
- **Timeout:** `mem_ack` never asserted, TIMEOUT=15.
  - `mem_req` is high for 15 cycles, then low.
  - DONE shows `lsu_fault=1` for exactly 1 cycle and `read_data=0`.
  - Next IDLE accepts a new lw normally.
- **Reset mid-WAIT:** assert `rst` three cycles into WAIT.
  - `mem_req` falls before the next clock edge.
  - All outputs are 0.
  - A late `mem_ack` after `rst` is deasserted does not change `read_data`.
